// File: rtl/lsb_embed_sequencer_if.sv
// lsb_embed_sequencer_if
//  Message byte stream and pixel memory bus of the LSB embed sequencer.
//  Signals:
//   msg_valid / msg_data / msg_ready     message byte stream (valid/ready)
//   mem_rd_en / mem_addr / mem_rd_data   pixel memory read port
//   mem_wr_en / mem_wr_data              pixel memory write port (shares mem_addr)
//  Modports:
//   master  sequencer side (drives msg_ready and all memory strobes/address/write data)
//   slave   environment side (message source and pixel memory)
interface lsb_embed_sequencer_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              msg_valid;
    logic [7:0]        msg_data;
    logic              msg_ready;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport master (
        input  msg_valid, msg_data, mem_rd_data,
        output msg_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
    );

    modport slave (
        output msg_valid, msg_data, mem_rd_data,
        input  msg_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/lsb_embed_sequencer.sv
// lsb_embed_sequencer
//  Embeds a message into the least significant bits of the shared pixel memory.
//  Message bytes are taken LSB-first from a valid/ready stream, repacked into
//  BITS_PER_PIX-bit chunks, and each chunk replaces the low bits of one pixel
//  byte by read-modify-write at BASE_ADDR + k.
//  Ports:
//   clk       rising-edge clock
//   HRESETn   asynchronous active-low reset
//   start     1-cycle job request, ignored unless idle
//   msg_len   message length in bytes, sampled when start is accepted
//   bus       message stream + pixel memory bus (lsb_embed_sequencer_if.master)
//   busy      high from accepted start until done
//   done      1-cycle pulse, job complete
//   error     1-cycle pulse, job rejected (does not fit), memory untouched
//  Configuration macro:
//   STEGO_LEN_HEADER_EN  when defined, a 16-bit msg_len header (LSB-first) is
//                        embedded ahead of the payload.
module lsb_embed_sequencer #(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned NUM_BYTES    = 498000,
    parameter int unsigned BITS_PER_PIX = 3,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned BASE_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  HRESETn,
    input  logic                  start,
    input  logic [15:0]           msg_len,
    lsb_embed_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned B     = BITS_PER_PIX;
    localparam int unsigned BUF_W = 8 + B - 1;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);
    localparam int unsigned TOT_W = 21;
    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned CAP   = NUM_BYTES - BASE_ADDR;
    localparam logic [7:0]  CHUNK_MASK = 8'((1 << B) - 1);
`ifdef STEGO_LEN_HEADER_EN
    localparam int unsigned HDR_BITS  = 16;
    localparam logic [1:0]  HDR_BYTES = 2'd2;
`else
    localparam int unsigned HDR_BITS  = 0;
    localparam logic [1:0]  HDR_BYTES = 2'd0;
`endif

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FILL = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [BUF_W-1:0]  bit_buf_q, bit_buf_d;
    logic [CNT_W-1:0]  buf_cnt_q, buf_cnt_d;
    logic [15:0]       bytes_left_q, bytes_left_d;
    logic [1:0]        hdr_left_q, hdr_left_d;
    logic [TOT_W-1:0]  chunk_idx_q, chunk_idx_d;
    logic [TOT_W-1:0]  last_idx_q, last_idx_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
`ifdef STEGO_LEN_HEADER_EN
    logic [15:0]       len_q, len_d;
`endif

    logic              ready_q, ready_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [TOT_W-1:0]  total_bits;
    logic [TOT_W-1:0]  chunks;
    logic              too_big;

    // Chunk count for the job being requested (divisor is a constant)
    always_comb begin
        total_bits = TOT_W'(HDR_BITS) + (TOT_W'(msg_len) << 3);
        chunks     = (total_bits + TOT_W'(B - 1)) / TOT_W'(B);
        too_big    = 32'(chunks) > CAP;
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= S_IDLE;
            bit_buf_q    <= '0;
            buf_cnt_q    <= '0;
            bytes_left_q <= '0;
            hdr_left_q   <= '0;
            chunk_idx_q  <= '0;
            last_idx_q   <= '0;
            lat_q        <= '0;
`ifdef STEGO_LEN_HEADER_EN
            len_q        <= '0;
`endif
            ready_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_buf_q    <= bit_buf_d;
            buf_cnt_q    <= buf_cnt_d;
            bytes_left_q <= bytes_left_d;
            hdr_left_q   <= hdr_left_d;
            chunk_idx_q  <= chunk_idx_d;
            last_idx_q   <= last_idx_d;
            lat_q        <= lat_d;
`ifdef STEGO_LEN_HEADER_EN
            len_q        <= len_d;
`endif
            ready_q      <= ready_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next state, datapath and next-cycle output values
    always_comb begin
        state_d      = state_q;
        bit_buf_d    = bit_buf_q;
        buf_cnt_d    = buf_cnt_q;
        bytes_left_d = bytes_left_q;
        hdr_left_d   = hdr_left_q;
        chunk_idx_d  = chunk_idx_q;
        last_idx_d   = last_idx_q;
        lat_d        = lat_q;
`ifdef STEGO_LEN_HEADER_EN
        len_d        = len_q;
`endif
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        done_d       = 1'b0;
        error_d      = 1'b0;
        addr_d       = addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (too_big) begin
                        error_d = 1'b1;
                    end
`ifndef STEGO_LEN_HEADER_EN
                    else if (msg_len == 16'd0) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        state_d      = S_FILL;
                        busy_d       = 1'b1;
                        bytes_left_d = msg_len;
                        hdr_left_d   = HDR_BYTES;
                        chunk_idx_d  = '0;
                        last_idx_d   = chunks - TOT_W'(1);
                        bit_buf_d    = '0;
                        buf_cnt_d    = '0;
                        addr_d       = ADDR_W'(BASE_ADDR);
`ifdef STEGO_LEN_HEADER_EN
                        len_d        = msg_len;
`endif
                    end
                end
            end

            // New bits are OR'ed in above the valid ones; bits above buf_cnt are always zero
            S_FILL: begin
                if (buf_cnt_q >= CNT_W'(B)) begin
                    state_d = S_RD;
                    rd_en_d = 1'b1;
                end
`ifdef STEGO_LEN_HEADER_EN
                else if (hdr_left_q != 2'd0) begin
                    bit_buf_d  = bit_buf_q |
                                 (BUF_W'((hdr_left_q == 2'd2) ? len_q[7:0] : len_q[15:8]) << buf_cnt_q);
                    buf_cnt_d  = buf_cnt_q + CNT_W'(8);
                    hdr_left_d = hdr_left_q - 2'd1;
                end
`endif
                else if (bytes_left_q != 16'd0) begin
                    if (ready_q && bus.msg_valid) begin
                        bit_buf_d    = bit_buf_q | (BUF_W'(bus.msg_data) << buf_cnt_q);
                        buf_cnt_d    = buf_cnt_q + CNT_W'(8);
                        bytes_left_d = bytes_left_q - 16'd1;
                    end
                end else begin
                    // Source exhausted: the zero bits already above buf_cnt become padding
                    buf_cnt_d = CNT_W'(B);
                end
            end

            S_RD: begin
                state_d = S_WAIT;
                lat_d   = LAT_W'(RD_LAT - 1);
            end

            // Read data is valid in the last wait cycle
            S_WAIT: begin
                if (lat_q == '0) begin
                    state_d   = S_WR;
                    wr_en_d   = 1'b1;
                    wr_data_d = (bus.mem_rd_data & ~CHUNK_MASK) | (bit_buf_q[7:0] & CHUNK_MASK);
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            S_WR: begin
                bit_buf_d = bit_buf_q >> B;
                buf_cnt_d = buf_cnt_q - CNT_W'(B);
                if (chunk_idx_q == last_idx_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d     = S_FILL;
                    chunk_idx_d = chunk_idx_q + TOT_W'(1);
                    addr_d      = addr_q + ADDR_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Request a byte only when the next cycle is FILL and the buffer cannot yet form a chunk
        ready_d = (state_d == S_FILL) && (buf_cnt_d < CNT_W'(B)) &&
                  (hdr_left_d == 2'd0) && (bytes_left_d != 16'd0);
    end

    assign bus.msg_ready   = ready_q;
    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
endmodule

// File: tb/tb_lsb_embed_sequencer.sv
// tb_lsb_embed_sequencer
//  Directed bench for lsb_embed_sequencer with B=3, RD_LAT=1, BASE_ADDR=0 and a
//  99-byte pixel memory preset to 0xFF. Honours STEGO_LEN_HEADER_EN.
module tb_lsb_embed_sequencer;
    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned NUM_BYTES = 99;
`ifdef STEGO_LEN_HEADER_EN
    localparam logic [15:0] LEN_FIT = 16'd35;   // ceil(296/3) = 99 chunks
    localparam logic [15:0] LEN_BIG = 16'd36;   // ceil(304/3) = 102 chunks
    localparam logic [7:0]  EXP_T6 [8] = '{8'hF9, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'hF8};
`else
    localparam logic [15:0] LEN_FIT = 16'd37;   // ceil(296/3) = 99 chunks
    localparam logic [15:0] LEN_BIG = 16'd38;   // ceil(304/3) = 102 chunks
    localparam logic [7:0]  EXP_T1 [6] = '{8'hFD, 8'hFC, 8'hFA, 8'hFE, 8'hFB, 8'hF8};
    localparam logic [7:0]  EXP_T4 [4] = '{8'hFF, 8'hF8, 8'hF8, 8'hFF};
`endif

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [15:0] msg_len;
    logic        busy, done, error;
    int          n_checks = 0;
    int          n_pass   = 0;

    lsb_embed_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    lsb_embed_sequencer #(
        .ADDR_W(ADDR_W), .NUM_BYTES(NUM_BYTES), .BITS_PER_PIX(3), .RD_LAT(1), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .HRESETn(HRESETn), .start(start), .msg_len(msg_len),
        .bus(bus), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Pixel memory (1-cycle read latency) and event counters
    logic [7:0] mem [256];
    logic       preset = 1'b0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, ready_cyc = 0;
    int overlap_cnt = 0, done_busy_cnt = 0, beyond_cnt = 0;
    int watch_addr = 256;

    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
        end
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_rd_en) rd_cnt <= rd_cnt + 1;
        if (bus.mem_wr_en) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (error) err_cnt <= err_cnt + 1;
        if (bus.msg_ready) ready_cyc <= ready_cyc + 1;
        if (bus.msg_ready && (bus.mem_rd_en || bus.mem_wr_en)) overlap_cnt <= overlap_cnt + 1;
        if (done && busy) done_busy_cnt <= done_busy_cnt + 1;
        if ((bus.mem_rd_en || bus.mem_wr_en) && int'(bus.mem_addr) >= watch_addr)
            beyond_cnt <= beyond_cnt + 1;
    end

    task automatic do_preset();
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] len);
        @(posedge clk); #1;
        start = 1'b1; msg_len = len;
        @(posedge clk); #1;
        start = 1'b0; msg_len = 16'h0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        bus.msg_valid = 1'b1; bus.msg_data = b;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (bus.msg_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        bus.msg_valid = 1'b0; bus.msg_data = 8'h00;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) ok = 1'b1;
        end
    endtask

    // Full job; gap>=14 holds msg_valid low long enough for the sequencer to stall in FILL
    task automatic run_job(input logic [15:0] len, input int n, input logic [7:0] b0,
                           input logic [7:0] b1, input int gap, input bit restart, output bit ok);
        bit got;
        int d0, s0;
        ok = 1'b1;
        d0 = done_cnt;
        pulse_start(len);
        for (int i = 0; i < n; i++) begin
            send_byte((i == 0) ? b0 : b1, got);
            if (!got) ok = 1'b0;
            if (restart && i == 0) pulse_start(16'd5);
            if (i + 1 < n && gap >= 14) begin
                repeat (12) @(posedge clk);
                #1 s0 = rd_cnt + wr_cnt;
                repeat (gap - 12) @(posedge clk);
                #1;
                n_checks++;
                if (rd_cnt + wr_cnt != s0 || bus.msg_ready !== 1'b1)
                    $display("FAIL stall_quiet: strobes=%0d ready=%b, required strobes=0 ready=1",
                             rd_cnt + wr_cnt - s0, bus.msg_ready);
                else n_pass++;
            end
        end
        wait_done(d0, got);
        if (!got) ok = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; start = 1'b0; msg_len = 16'h0;
        bus.msg_valid = 1'b0; bus.msg_data = 8'h00;
        preset = 1'b1;
        repeat (3) @(posedge clk); #1;
        preset = 1'b0;
        n_checks++;
        if ({busy, done, error} !== 3'b000)
            $display("FAIL reset_status: busy/done/error=%b, required 000", {busy, done, error});
        else n_pass++;
        n_checks++;
        if ({bus.msg_ready, bus.mem_rd_en, bus.mem_wr_en} !== 3'b000)
            $display("FAIL reset_strobes: ready/rd/wr=%b, required 000",
                     {bus.msg_ready, bus.mem_rd_en, bus.mem_wr_en});
        else n_pass++;
        n_checks++;
        if (bus.mem_addr !== 8'h00 || bus.mem_wr_data !== 8'h00)
            $display("FAIL reset_bus: addr=%h wr_data=%h, required 00 00", bus.mem_addr, bus.mem_wr_data);
        else n_pass++;
        HRESETn = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef STEGO_LEN_HEADER_EN
    task automatic test_header();
        bit ok;
        int w0, d0;
        do_preset();
        watch_addr = 8;
        w0 = wr_cnt; d0 = done_cnt;
        run_job(16'd1, 1, 8'h00, 8'h00, 0, 1'b0, ok);
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL hdr_job: completed=%b, required 1", ok); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (mem[i] !== EXP_T6[i])
                $display("FAIL hdr_mem[%0d]: got %h, required %h", i, mem[i], EXP_T6[i]);
            else n_pass++;
        end
        n_checks++;
        if (mem[8] !== 8'hFF || beyond_cnt != 0)
            $display("FAIL hdr_bound: mem[8]=%h beyond=%0d, required FF 0", mem[8], beyond_cnt);
        else n_pass++;
        n_checks++;
        if (wr_cnt - w0 != 8 || done_cnt - d0 != 1)
            $display("FAIL hdr_counts: writes=%0d dones=%0d, required 8 1", wr_cnt - w0, done_cnt - d0);
        else n_pass++;
        watch_addr = 256;
    endtask
`else
    task automatic test_basic();
        bit ok;
        int r0, w0, d0;
        do_preset();
        watch_addr = 6;
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        run_job(16'd2, 2, 8'hA5, 8'h3C, 0, 1'b0, ok);
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_job: completed=%b, required 1", ok); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (mem[i] !== EXP_T1[i])
                $display("FAIL basic_mem[%0d]: got %h, required %h", i, mem[i], EXP_T1[i]);
            else n_pass++;
        end
        n_checks++;
        if (mem[6] !== 8'hFF || beyond_cnt != 0)
            $display("FAIL basic_bound: mem[6]=%h beyond=%0d, required FF 0", mem[6], beyond_cnt);
        else n_pass++;
        n_checks++;
        if (rd_cnt - r0 != 6 || wr_cnt - w0 != 6)
            $display("FAIL basic_strobes: reads=%0d writes=%0d, required 6 6", rd_cnt - r0, wr_cnt - w0);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1 || done_busy_cnt != 0)
            $display("FAIL basic_done: pulses=%0d done_with_busy=%0d, required 1 0",
                     done_cnt - d0, done_busy_cnt);
        else n_pass++;
        watch_addr = 256;
    endtask

    task automatic test_stall();
        bit ok;
        int w0;
        do_preset();
        w0 = wr_cnt;
        run_job(16'd2, 2, 8'hA5, 8'h3C, 14, 1'b0, ok);
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL stall_job: completed=%b, required 1", ok); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (mem[i] !== EXP_T1[i])
                $display("FAIL stall_mem[%0d]: got %h, required %h", i, mem[i], EXP_T1[i]);
            else n_pass++;
        end
        n_checks++;
        if (wr_cnt - w0 != 6 || overlap_cnt != 0)
            $display("FAIL stall_counts: writes=%0d ready_with_strobe=%0d, required 6 0",
                     wr_cnt - w0, overlap_cnt);
        else n_pass++;
    endtask

    task automatic test_start_while_busy();
        bit ok;
        int w0, d0;
        do_preset();
        w0 = wr_cnt; d0 = done_cnt;
        run_job(16'd2, 2, 8'hA5, 8'h3C, 0, 1'b1, ok);
        repeat (5) @(posedge clk); #1;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL busy_start_job: completed=%b, required 1", ok); else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 1 || wr_cnt - w0 != 6 || busy !== 1'b0)
            $display("FAIL busy_start_counts: dones=%0d writes=%0d busy=%b, required 1 6 0",
                     done_cnt - d0, wr_cnt - w0, busy);
        else n_pass++;
        n_checks++;
        if (mem[5] !== 8'hF8 || mem[6] !== 8'hFF)
            $display("FAIL busy_start_mem: mem[5]=%h mem[6]=%h, required F8 FF", mem[5], mem[6]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        int w0, s0;
        do_preset();
        w0 = wr_cnt;
        pulse_start(16'd2);
        send_byte(8'hA5, ok);
        for (int c = 0; c < 50 && (wr_cnt - w0) < 2; c++) begin
            @(posedge clk); #1;
        end
        #1 HRESETn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, error, bus.msg_ready, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr} !== 14'h0)
            $display("FAIL abort_outputs: busy=%b ready=%b rd=%b wr=%b addr=%h, required all 0",
                     busy, bus.msg_ready, bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr);
        else n_pass++;
        s0 = rd_cnt + wr_cnt;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (rd_cnt + wr_cnt != s0 || wr_cnt - w0 != 2)
            $display("FAIL abort_strobes: during_reset=%0d writes=%0d, required 0 2",
                     rd_cnt + wr_cnt - s0, wr_cnt - w0);
        else n_pass++;
        n_checks++;
        if (mem[0] !== 8'hFD || mem[1] !== 8'hFC || mem[2] !== 8'hFF)
            $display("FAIL abort_partial: mem0..2=%h %h %h, required FD FC FF", mem[0], mem[1], mem[2]);
        else n_pass++;
        HRESETn = 1'b1;
        @(posedge clk); #1;
        run_job(16'd1, 1, 8'h07, 8'h00, 0, 1'b0, ok);
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (ok !== 1'b1) $display("FAIL restart_job: completed=%b, required 1", ok); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[i] !== EXP_T4[i])
                $display("FAIL restart_mem[%0d]: got %h, required %h", i, mem[i], EXP_T4[i]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        int s0;
        s0 = rd_cnt + wr_cnt;
        pulse_start(16'd0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL zero_len_done: done=%b busy=%b, required 1 0", done, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || rd_cnt + wr_cnt != s0)
            $display("FAIL zero_len_after: done=%b strobes=%0d, required 0 0", done, rd_cnt + wr_cnt - s0);
        else n_pass++;
    endtask
`endif

    task automatic test_error();
        int s0, r0, e0;
        do_preset();
        s0 = rd_cnt + wr_cnt; r0 = ready_cyc; e0 = err_cnt;
        pulse_start(16'hFFFF);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0)
            $display("FAIL err_pulse: error=%b busy=%b, required 1 0", error, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (error !== 1'b0) $display("FAIL err_width: error=%b, required 0", error); else n_pass++;
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (rd_cnt + wr_cnt != s0 || ready_cyc != r0 || err_cnt - e0 != 1 || busy !== 1'b0)
            $display("FAIL err_quiet: strobes=%0d ready_cycles=%0d errors=%0d busy=%b, required 0 0 1 0",
                     rd_cnt + wr_cnt - s0, ready_cyc - r0, err_cnt - e0, busy);
        else n_pass++;
        pulse_start(LEN_BIG);
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0)
            $display("FAIL err_over_cap: error=%b busy=%b, required 1 0", error, busy);
        else n_pass++;
        @(posedge clk); #1;
        pulse_start(LEN_FIT);
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b1)
            $display("FAIL fit_cap: error=%b busy=%b, required 0 1", error, busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        #2 HRESETn = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus.msg_ready !== 1'b0)
            $display("FAIL fit_abort: busy=%b ready=%b, required 0 0", busy, bus.msg_ready);
        else n_pass++;
        @(posedge clk); #1;
        HRESETn = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
`ifdef STEGO_LEN_HEADER_EN
        test_header();
`else
        test_basic();
        test_stall();
        test_start_while_busy();
        test_reset_mid_job();
        test_zero_len();
`endif
        test_error();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
